// File: rtl/pcs_pkg.sv
// Shared PCS block widths and word types.
// Used by the loopback frame checker and its delay line.
package pcs_pkg;

    localparam int LEN_DATA_BLOCK  = 64;
    localparam int LEN_CTRL_BLOCK  = 8;
    localparam int LEN_CODED_BLOCK = 66;

    typedef logic [LEN_DATA_BLOCK-1:0] data_block_t;
    typedef logic [LEN_CTRL_BLOCK-1:0] ctrl_block_t;

    typedef struct packed {
        ctrl_block_t ctrl;
        data_block_t data;
    } tx_word_t;

endpackage

// File: rtl/frame_checker_delay_line.sv
// Reference delay line: circular buffer of tx words, write pointer,
// warm-up fill counter and reset-latched latency.
// Ports: i_clock, i_reset (sync, active-high), i_enable, i_latency,
//        i_tx_word in; o_ref_word (tx word latency_q cycles ago), o_active out.
module frame_checker_delay_line
    import pcs_pkg::*;
#(
    parameter int MAX_LATENCY = 32,
    parameter int LEN_LATENCY = 5
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic [LEN_LATENCY-1:0] i_latency,
    input  tx_word_t               i_tx_word,
    output tx_word_t               o_ref_word,
    output logic                   o_active
);

    localparam logic [31:0] MAX_LAT_M1 = 32'(MAX_LATENCY - 1);
    localparam logic [LEN_LATENCY-1:0] PTR_LAST = LEN_LATENCY'(MAX_LATENCY - 1);
    localparam logic [LEN_LATENCY-1:0] PTR_DEPTH = LEN_LATENCY'(MAX_LATENCY);

    tx_word_t               mem_q [MAX_LATENCY];
    logic [LEN_LATENCY-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_LATENCY-1:0] fill_q, fill_d;
    logic [LEN_LATENCY-1:0] latency_q, latency_d;
    logic [LEN_LATENCY-1:0] rd_ptr;
    logic [31:0]            lat_ext;

    always_comb begin
        lat_ext   = 32'(i_latency);
        latency_d = (lat_ext > MAX_LAT_M1) ? PTR_LAST : i_latency;

        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + LEN_LATENCY'(1);

        // Slot written latency_q enabled cycles ago, with modular wrap.
        if (wr_ptr_q >= latency_q) begin
            rd_ptr = wr_ptr_q - latency_q;
        end else begin
            rd_ptr = wr_ptr_q + PTR_DEPTH - latency_q;
        end

        o_active = (fill_q == latency_q);
        fill_d   = o_active ? fill_q : fill_q + LEN_LATENCY'(1);

        // Zero latency compares against the word being sent right now.
        o_ref_word = (latency_q == '0) ? i_tx_word : mem_q[rd_ptr];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < MAX_LATENCY; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            latency_q <= latency_d;
        end else if (i_enable) begin
            mem_q[wr_ptr_q] <= i_tx_word;
            wr_ptr_q        <= wr_ptr_d;
            fill_q          <= fill_d;
        end
    end

endmodule

// File: rtl/frame_checker.sv
// PCS TX->RX loopback checker: compares rx words with delayed tx words.
// Ports: clock/reset/enable, latency, tx and raw rx words in; registered
//        match flags, valid and saturating block/error counters out.
module frame_checker
    import pcs_pkg::*;
#(
    parameter int MAX_LATENCY = 32,
    parameter int LEN_LATENCY = 5,
    parameter int LEN_COUNTER = 32
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic [LEN_LATENCY-1:0] i_latency,
    input  data_block_t            i_tx_data,
    input  ctrl_block_t            i_tx_ctrl,
    input  data_block_t            i_rx_raw_data,
    input  ctrl_block_t            i_rx_raw_ctrl,
    output logic                   o_match_data,
    output logic                   o_match_ctrl,
    output logic                   o_valid,
    output logic [LEN_COUNTER-1:0] o_block_count,
    output logic [LEN_COUNTER-1:0] o_err_data_count,
    output logic [LEN_COUNTER-1:0] o_err_ctrl_count
);

    tx_word_t ref_word;
    tx_word_t tx_word;
    logic     active;

    logic                   match_data_q, match_data_d;
    logic                   match_ctrl_q, match_ctrl_d;
    logic                   valid_q, valid_d;
    logic [LEN_COUNTER-1:0] blk_q, blk_d;
    logic [LEN_COUNTER-1:0] err_d_q, err_d_d;
    logic [LEN_COUNTER-1:0] err_c_q, err_c_d;

    assign tx_word.ctrl = i_tx_ctrl;
    assign tx_word.data = i_tx_data;

    frame_checker_delay_line #(
        .MAX_LATENCY(MAX_LATENCY),
        .LEN_LATENCY(LEN_LATENCY)
    ) u_delay (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_enable  (i_enable),
        .i_latency (i_latency),
        .i_tx_word (tx_word),
        .o_ref_word(ref_word),
        .o_active  (active)
    );

    always_comb begin
        match_data_d = 1'b1;
        match_ctrl_d = 1'b1;
        valid_d      = active;
        blk_d        = blk_q;
        err_d_d      = err_d_q;
        err_c_d      = err_c_q;
        if (active) begin
            match_data_d = (i_rx_raw_data == ref_word.data);
            match_ctrl_d = (i_rx_raw_ctrl == ref_word.ctrl);
            // Counters stick at all-ones instead of wrapping.
            if (blk_q != '1) begin
                blk_d = blk_q + LEN_COUNTER'(1);
            end
            if (!match_data_d && err_d_q != '1) begin
                err_d_d = err_d_q + LEN_COUNTER'(1);
            end
            if (!match_ctrl_d && err_c_q != '1) begin
                err_c_d = err_c_q + LEN_COUNTER'(1);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            match_data_q <= 1'b1;
            match_ctrl_q <= 1'b1;
            valid_q      <= 1'b0;
            blk_q        <= '0;
            err_d_q      <= '0;
            err_c_q      <= '0;
        end else if (i_enable) begin
            match_data_q <= match_data_d;
            match_ctrl_q <= match_ctrl_d;
            valid_q      <= valid_d;
            blk_q        <= blk_d;
            err_d_q      <= err_d_d;
            err_c_q      <= err_c_d;
        end
    end

    assign o_match_data     = match_data_q;
    assign o_match_ctrl     = match_ctrl_q;
    assign o_valid          = valid_q;
    assign o_block_count    = blk_q;
    assign o_err_data_count = err_d_q;
    assign o_err_ctrl_count = err_c_q;

endmodule

// File: tb/tb_frame_checker.sv
// Self-checking bench for frame_checker with a scoreboard queue.
// A second instance with 4-bit counters sees a permanent data mismatch.
module tb_frame_checker;
    import pcs_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [4:0]  lat;
    logic [63:0] txd, rxd, rxd2;
    logic [7:0]  txc, rxc;

    logic        md, mc, v;
    logic [31:0] blk, ed, ec;
    logic        md2, mc2, v2;
    logic [3:0]  blk2, ed2, ec2;

    always #5 clk = ~clk;

    assign rxd2 = rxd ^ 64'd1;

    frame_checker dut (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_latency(lat),
        .i_tx_data(txd), .i_tx_ctrl(txc),
        .i_rx_raw_data(rxd), .i_rx_raw_ctrl(rxc),
        .o_match_data(md), .o_match_ctrl(mc), .o_valid(v),
        .o_block_count(blk), .o_err_data_count(ed), .o_err_ctrl_count(ec)
    );

    frame_checker #(.LEN_COUNTER(4)) dut4 (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_latency(lat),
        .i_tx_data(txd), .i_tx_ctrl(txc),
        .i_rx_raw_data(rxd2), .i_rx_raw_ctrl(rxc),
        .o_match_data(md2), .o_match_ctrl(mc2), .o_valid(v2),
        .o_block_count(blk2), .o_err_data_count(ed2), .o_err_ctrl_count(ec2)
    );

    typedef struct {
        logic        v, md, mc;
        logic [31:0] blk, ed, ec;
        logic [3:0]  b2, e2;
    } exp_t;

    exp_t        sbq[$];
    exp_t        m;
    logic [71:0] hist[$];
    int          m_lat, m_k;
    int          checks = 0, failures = 0;
    int          n = 1000;
    int          first_v;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [4:0] l,
                        input logic [63:0] td, input logic [7:0] tc,
                        input logic [63:0] rd, input logic [7:0] rc);
        logic [71:0] rw;
        logic        dok, cok, d2ok;
        exp_t        x;
        rst = r; en = e; lat = l;
        txd = td; txc = tc; rxd = rd; rxc = rc;
        if (r) begin
            m_lat = int'(l);
            m_k = 0;
            hist.delete();
            m.v = 0; m.md = 1; m.mc = 1;
            m.blk = 0; m.ed = 0; m.ec = 0; m.b2 = 0; m.e2 = 0;
        end else if (e) begin
            hist.push_front({tc, td});
            if (hist.size() > 40) void'(hist.pop_back());
            if (m_k >= m_lat) begin
                rw   = hist[m_lat];
                dok  = (rd == rw[63:0]);
                cok  = (rc == rw[71:64]);
                d2ok = ((rd ^ 64'd1) == rw[63:0]);
                m.v = 1; m.md = dok; m.mc = cok;
                m.blk++;
                if (!dok) m.ed++;
                if (!cok) m.ec++;
                if (m.b2 != 4'hF) m.b2++;
                if (!d2ok && m.e2 != 4'hF) m.e2++;
            end else begin
                m.v = 0; m.md = 1; m.mc = 1;
                m_k++;
            end
        end
        sbq.push_back(m);
        @(posedge clk);
        #1;
        x = sbq.pop_front();
        chk("valid", 64'(v), 64'(x.v));
        chk("match_data", 64'(md), 64'(x.md));
        chk("match_ctrl", 64'(mc), 64'(x.mc));
        chk("block_count", 64'(blk), 64'(x.blk));
        chk("err_data", 64'(ed), 64'(x.ed));
        chk("err_ctrl", 64'(ec), 64'(x.ec));
        chk("block_count4", 64'(blk2), 64'(x.b2));
        chk("err_data4", 64'(ed2), 64'(x.e2));
    endtask

    // Counting tx stream; rx is the same stream delayed by slat blocks.
    task automatic stream(input int cycles, input int slat, input int ilat,
                          input int flip_at, input int cflip_n);
        logic [63:0] td, rd;
        logic [7:0]  tc, rc;
        int          rn;
        for (int i = 0; i < cycles; i++) begin
            rn = n - slat;
            td = 64'(n % 256);
            tc = (n % 2 == 1) ? 8'hFF : 8'h00;
            rd = 64'(rn % 256);
            rc = (rn % 2 == 1) ? 8'hFF : 8'h00;
            if (i == flip_at) rd = rd ^ 64'h20;
            if (i < cflip_n) rc = rc ^ 8'h01;
            step(1'b0, 1'b1, 5'(ilat), td, tc, rd, rc);
            if (first_v < 0 && v) first_v = i + 1;
            n++;
        end
    endtask

    task automatic reset_to(input int l);
        step(1'b1, 1'b1, 5'(l), 64'hDEAD, 8'hA5, 64'hBEEF, 8'h5A);
        first_v = -1;
    endtask

    logic [31:0] blk_hold;

    initial begin
        rst = 1; en = 1; lat = 0;
        txd = 0; txc = 0; rxd = 0;
        rxc = 0;
        first_v = -1;

        reset_to(3);
        chk("rst_valid", 64'(v), 64'd0);
        chk("rst_block", 64'(blk), 64'd0);
        stream(103, 3, 3, -1, 0);
        chk("valid_rise_l3", 64'(first_v), 64'd4);
        chk("blocks_100", 64'(blk), 64'd100);
        chk("no_err_data", 64'(ed), 64'd0);
        chk("no_err_ctrl", 64'(ec), 64'd0);

        stream(1, 3, 3, 0, 0);
        chk("flip_md", 64'(md), 64'd0);
        chk("flip_mc", 64'(mc), 64'd1);
        chk("flip_ed", 64'(ed), 64'd1);
        chk("flip_ec", 64'(ec), 64'd0);
        stream(10, 3, 3, -1, 0);

        blk_hold = blk;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 5'($urandom_range(31)),
                 {$urandom, $urandom}, 8'($urandom),
                 {$urandom, $urandom}, 8'($urandom));
        end
        chk("hold_block", 64'(blk), 64'(blk_hold));
        stream(10, 3, 3, -1, 0);
        chk("resume_block", 64'(blk), 64'(blk_hold) + 64'd10);

        reset_to(0);
        chk("mid_rst_valid", 64'(v), 64'd0);
        chk("mid_rst_md", 64'(md), 64'd1);
        chk("mid_rst_ed", 64'(ed), 64'd0);
        stream(10, 0, 5, -1, 4);
        chk("ctrl_err_4", 64'(ec), 64'd4);
        chk("l0_blocks", 64'(blk), 64'd10);

        reset_to(7);
        stream(30, 7, 2, -1, 0);
        chk("valid_rise_l7", 64'(first_v), 64'd8);

        reset_to(31);
        stream(60, 31, 31, -1, 0);
        chk("l31_blocks", 64'(blk), 64'd29);
        chk("l31_err", 64'(ed), 64'd0);
        chk("sat_err4", 64'(ed2), 64'd15);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 5'd1, 64'd0, 8'd0, 64'd7, 8'd3);
        end
        chk("sat_hold4", 64'(ed2), 64'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
